// File: rtl/sdio_dat_rx.sv
// rtl/sdio_dat_rx.sv - SDIO DAT0 single-block receiver with CRC16 check
module sdio_dat_rx (
    input  logic        sd_clk,
    input  logic        rstn,
    input  logic        sd_rst,
    input  logic        rx_start,
    input  logic [11:0] blk_len,
    input  logic [15:0] rx_timeout,
    input  logic        dat_in,
    output logic [7:0]  rx_byte,
    output logic        rx_byte_vld,
    output logic        rx_busy,
    output logic        rx_done,
    output logic        rx_crc_err,
    output logic        rx_end_err,
    output logic        rx_timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_END, S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [11:0] len_q;
    logic [15:0] to_q;
    logic [15:0] wait_cnt;
    logic [14:0] bit_cnt;
    logic [3:0]  crc_cnt;
    logic [15:0] crc_q;
    logic [15:0] rx_crc;
    logic [6:0]  sh;
    logic        fb;
    logic        last_bit;
    logic        wait_hit;

    assign fb = crc_q[15] ^ dat_in;
    // len_q - 1 wraps 0 to 4095, so a latched 0 naturally means 4096 bytes
    assign last_bit = (bit_cnt == {len_q - 12'd1, 3'b111});
    assign wait_hit = dat_in && (to_q != 16'd0) &&
                      (({1'b0, wait_cnt} + 17'd1) == {1'b0, to_q});

    always_ff @(posedge sd_clk or negedge rstn) begin
        if (!rstn)       state <= S_IDLE;
        else if (sd_rst) state <= S_IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (rx_start) state_nxt = S_WAIT_START;
            S_WAIT_START: begin
                if (!dat_in)       state_nxt = S_DATA;
                else if (wait_hit) state_nxt = S_DONE;
            end
            S_DATA:       if (last_bit) state_nxt = S_CRC;
            S_CRC:        if (crc_cnt == 4'd15) state_nxt = S_END;
            S_END:        state_nxt = S_DONE;
            S_DONE:       state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rx_busy = 1'b0;
        rx_done = 1'b0;
        case (state)
            S_WAIT_START, S_DATA, S_CRC, S_END: rx_busy = 1'b1;
            S_DONE:                             rx_done = 1'b1;
            default:                            ;
        endcase
    end

    always_ff @(posedge sd_clk or negedge rstn) begin
        if (!rstn) begin
            len_q          <= '0;
            to_q           <= '0;
            wait_cnt       <= '0;
            bit_cnt        <= '0;
            crc_cnt        <= '0;
            crc_q          <= '0;
            rx_crc         <= '0;
            sh             <= '0;
            rx_byte        <= '0;
            rx_byte_vld    <= 1'b0;
            rx_crc_err     <= 1'b0;
            rx_end_err     <= 1'b0;
            rx_timeout_err <= 1'b0;
        end else if (sd_rst) begin
            len_q          <= '0;
            to_q           <= '0;
            wait_cnt       <= '0;
            bit_cnt        <= '0;
            crc_cnt        <= '0;
            crc_q          <= '0;
            rx_crc         <= '0;
            sh             <= '0;
            rx_byte        <= '0;
            rx_byte_vld    <= 1'b0;
            rx_crc_err     <= 1'b0;
            rx_end_err     <= 1'b0;
            rx_timeout_err <= 1'b0;
        end else begin
            rx_byte_vld <= 1'b0;
            case (state)
                S_IDLE: if (rx_start) begin
                    len_q          <= blk_len;
                    to_q           <= rx_timeout;
                    wait_cnt       <= '0;
                    bit_cnt        <= '0;
                    crc_cnt        <= '0;
                    crc_q          <= '0;
                    rx_crc         <= '0;
                    rx_crc_err     <= 1'b0;
                    rx_end_err     <= 1'b0;
                    rx_timeout_err <= 1'b0;
                end
                S_WAIT_START: if (dat_in) begin
                    wait_cnt <= wait_cnt + 16'd1;
                    if (wait_hit) rx_timeout_err <= 1'b1;
                end
                S_DATA: begin
                    crc_q   <= {crc_q[14:12], crc_q[11] ^ fb, crc_q[10:5],
                                crc_q[4] ^ fb, crc_q[3:0], fb};
                    sh      <= {sh[5:0], dat_in};
                    bit_cnt <= bit_cnt + 15'd1;
                    if (bit_cnt[2:0] == 3'd7) begin
                        rx_byte     <= {sh, dat_in};
                        rx_byte_vld <= 1'b1;
                    end
                end
                S_CRC: begin
                    rx_crc  <= {rx_crc[14:0], dat_in};
                    crc_cnt <= crc_cnt + 4'd1;
                end
                S_END: begin
                    rx_end_err <= ~dat_in;
                    rx_crc_err <= (rx_crc != crc_q);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdio_dat_rx.sv
// tb/tb_sdio_dat_rx.sv - scoreboard bench for sdio_dat_rx
module tb_sdio_dat_rx;

    logic        sd_clk;
    logic        rstn;
    logic        sd_rst;
    logic        rx_start;
    logic [11:0] blk_len;
    logic [15:0] rx_timeout;
    logic        dat_in;
    logic [7:0]  rx_byte;
    logic        rx_byte_vld;
    logic        rx_busy;
    logic        rx_done;
    logic        rx_crc_err;
    logic        rx_end_err;
    logic        rx_timeout_err;

    sdio_dat_rx dut (
        .sd_clk(sd_clk), .rstn(rstn), .sd_rst(sd_rst), .rx_start(rx_start),
        .blk_len(blk_len), .rx_timeout(rx_timeout), .dat_in(dat_in),
        .rx_byte(rx_byte), .rx_byte_vld(rx_byte_vld), .rx_busy(rx_busy),
        .rx_done(rx_done), .rx_crc_err(rx_crc_err), .rx_end_err(rx_end_err),
        .rx_timeout_err(rx_timeout_err)
    );

    typedef struct { logic [7:0] d; int c; } bexp_t;
    typedef struct { int c; logic ce; logic ee; logic te; } dexp_t;

    bexp_t      byte_q[$];
    dexp_t      done_q[$];
    logic [7:0] data_mem [4096];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;

    initial sd_clk = 1'b0;
    always #5 sd_clk = ~sd_clk;
    always @(posedge sd_clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // Reference CRC16-CCITT (poly 0x1021, init 0) over the first n bytes of data_mem
    function automatic logic [15:0] crc16(input int n);
        logic [15:0] c;
        logic        f;
        c = 16'h0;
        for (int i = 0; i < n; i++)
            for (int b = 7; b >= 0; b--) begin
                f = c[15] ^ data_mem[i][b];
                c = {c[14:0], 1'b0} ^ (f ? 16'h1021 : 16'h0000);
            end
        return c;
    endfunction

    always @(negedge sd_clk) begin
        if (rstn) begin
            if (rx_byte_vld) begin
                if (byte_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_byte: got %0h expected none (cycle %0d)", rx_byte, cyc);
                end else begin
                    bexp_t e;
                    e = byte_q.pop_front();
                    chk("rx_byte", {24'h0, rx_byte}, {24'h0, e.d});
                    chk("byte_cycle", cyc, e.c);
                end
            end
            if (rx_done) begin
                if (done_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_done: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    dexp_t e;
                    e = done_q.pop_front();
                    chk("done_cycle", cyc, e.c);
                    chk("crc_err", {31'h0, rx_crc_err}, {31'h0, e.ce});
                    chk("end_err", {31'h0, rx_end_err}, {31'h0, e.ee});
                    chk("timeout_err", {31'h0, rx_timeout_err}, {31'h0, e.te});
                    chk("busy_at_done", {31'h0, rx_busy}, 32'h0);
                end
            end
        end
    end

    task automatic drive(input logic b);
        dat_in = b;
        @(negedge sd_clk);
    endtask

    task automatic start(input logic [11:0] len, input logic [15:0] to);
        @(negedge sd_clk);
        blk_len    = len;
        rx_timeout = to;
        rx_start   = 1'b1;
        dat_in     = 1'b1;
        @(negedge sd_clk);
        rx_start   = 1'b0;
        chk("busy_after_start", {31'h0, rx_busy}, 32'h1);
    endtask

    // Sends a block; stop_after >= 0 aborts with sd_rst after that many data bits
    task automatic send_block(input logic [11:0] len, input int nbytes, input logic [15:0] crc_val,
                              input logic exp_ce, input logic end_bit, input int gap,
                              input logic [15:0] to, input bit poke, input int stop_after);
        int nb;
        nb = 0;
        start(len, to);
        for (int g = 0; g < gap; g++) drive(1'b1);
        drive(1'b0);
        for (int i = 0; i < nbytes; i++)
            for (int b = 7; b >= 0; b--) begin
                if (stop_after >= 0 && nb == stop_after) begin
                    sd_rst = 1'b1;
                    @(negedge sd_clk);
                    sd_rst = 1'b0;
                    chk("busy_after_sd_rst", {31'h0, rx_busy}, 32'h0);
                    chk("byte_after_sd_rst", {24'h0, rx_byte}, 32'h0);
                    chk("done_after_sd_rst", {31'h0, rx_done}, 32'h0);
                    for (int k = 0; k < 6; k++) drive(1'b1);
                    return;
                end
                if (poke && i == 1 && b == 4) begin
                    rx_start = 1'b1;
                    blk_len  = 12'd1;
                end
                if (b == 0) byte_q.push_back('{d: data_mem[i], c: cyc + 1});
                drive(data_mem[i][b]);
                rx_start = 1'b0;
                nb++;
            end
        for (int b = 15; b >= 0; b--) drive(crc_val[b]);
        done_q.push_back('{c: cyc + 1, ce: exp_ce, ee: ~end_bit, te: 1'b0});
        drive(end_bit);
        drive(1'b1);
        drive(1'b1);
    endtask

    task automatic send_timeout(input logic [15:0] to);
        int s;
        @(negedge sd_clk);
        s = cyc;
        blk_len    = 12'd4;
        rx_timeout = to;
        rx_start   = 1'b1;
        dat_in     = 1'b1;
        done_q.push_back('{c: s + int'(to) + 1, ce: 1'b0, ee: 1'b0, te: 1'b1});
        @(negedge sd_clk);
        rx_start = 1'b0;
        for (int k = 0; k < int'(to) + 3; k++) drive(1'b1);
    endtask

    initial begin
        rstn = 1'b0; sd_rst = 1'b0; rx_start = 1'b0;
        blk_len = 12'd0; rx_timeout = 16'd0; dat_in = 1'b0;
        #12;
        chk("reset_outputs",
            {24'h0, rx_byte, rx_byte_vld, rx_busy, rx_done, rx_crc_err, rx_end_err, rx_timeout_err},
            32'h0);
        @(negedge sd_clk);
        rstn = 1'b1;
        for (int k = 0; k < 5; k++) drive(k[0]);
        chk("idle_ignores_dat", {31'h0, rx_busy | rx_byte_vld | rx_done}, 32'h0);

        for (int i = 0; i < 512; i++) data_mem[i] = 8'hFF;
        send_block(12'd512, 512, 16'h7FA1, 1'b0, 1'b1, 2, 16'd0, 1'b0, -1);
        send_block(12'd512, 512, 16'h7FA0, 1'b1, 1'b1, 0, 16'd0, 1'b0, -1);

        data_mem[0] = 8'hA5;
        send_block(12'd1, 1, crc16(1), 1'b0, 1'b0, 1, 16'd0, 1'b0, -1);

        send_timeout(16'd10);

        for (int i = 0; i < 512; i++) data_mem[i] = 8'($urandom);
        send_block(12'd512, 512, crc16(512), 1'b0, 1'b1, 0, 16'd0, 1'b0, 3 * 8 + 4);
        send_block(12'd512, 512, crc16(512), 1'b0, 1'b1, 1, 16'd0, 1'b0, -1);

        send_block(12'd3, 3, crc16(3), 1'b0, 1'b1, 0, 16'd0, 1'b1, -1);

        for (int i = 0; i < 4096; i++) data_mem[i] = 8'($urandom);
        send_block(12'd0, 4096, crc16(4096), 1'b0, 1'b1, 0, 16'd3, 1'b0, -1);

        for (int it = 0; it < 30; it++) begin
            int          len, gap;
            logic [15:0] to, flip;
            logic        eb;
            bit          pk;
            if (it % 6 == 5) begin
                send_timeout(16'($urandom_range(1, 20)));
            end else begin
                len = $urandom_range(1, 6);
                gap = $urandom_range(0, 4);
                for (int i = 0; i < len; i++) data_mem[i] = 8'($urandom);
                to   = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'(gap + 1 + $urandom_range(0, 3));
                flip = ($urandom_range(0, 3) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0;
                eb   = ($urandom_range(0, 3) != 0);
                pk   = (len > 1) && ($urandom_range(0, 3) == 0);
                send_block(12'(len), len, crc16(len) ^ flip, flip != 16'h0, eb, gap, to, pk, -1);
            end
        end

        for (int k = 0; k < 20; k++) drive(1'b1);
        chk("bytes_outstanding", byte_q.size(), 32'h0);
        chk("dones_outstanding", done_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sdio_dat_rx.md
SDIO_DAT_RX -- requirements
Module: sdio_dat_rx

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset; all state updates on the rising edge of sd_clk.
REQ-002 sd_clk  input  1  card clock; DAT0 is sampled on the rising edge.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 sd_rst  input  1  synchronous soft reset, active-high; highest priority after rstn.
REQ-005 rx_start  input  1  one-cycle pulse that arms reception of one block.
REQ-006 blk_len  input  12  block length in bytes, latched at rx_start; 0 means 4096.
REQ-007 rx_timeout  input  16  start-bit timeout in sd_clk cycles, latched at rx_start; 0 disables the timeout.
REQ-008 dat_in  input  1  serial DAT0 line, already synchronised.
REQ-009 rx_byte  output  8  received data byte, MSB received first.
REQ-010 rx_byte_vld  output  1  one-cycle strobe qualifying rx_byte.
REQ-011 rx_busy  output  1  high from the cycle after an accepted rx_start until rx_done.
REQ-012 rx_done  output  1  one-cycle pulse marking end of block or timeout.
REQ-013 rx_crc_err, rx_end_err, rx_timeout_err  output  1 each  status flags, valid with rx_done and held until the next accepted rx_start.

Function
REQ-014 States SHALL be IDLE, WAIT_START, DATA, CRC, END, DONE.
- IDLE -> WAIT_START on rx_start.
- WAIT_START -> DATA on dat_in=0.
- DATA -> CRC after blk_len*8 bits.
- CRC -> END after 16 bits.
- END -> DONE after 1 bit.
- DONE -> IDLE unconditionally.
REQ-015 In IDLE, rx_start SHALL latch blk_len and rx_timeout, clear all three status flags, and clear the CRC register and counters.
REQ-016 rx_start SHALL be ignored in every state other than IDLE.
REQ-017 In WAIT_START, a sample of dat_in=1 SHALL increment a 16-bit wait counter.
REQ-018 If rx_timeout is nonzero and the wait counter equals rx_timeout, the block SHALL set rx_timeout_err and go to DONE.
REQ-019 The start bit SHALL NOT enter the CRC; the first DATA sample is data bit 7 of byte 0.
REQ-020 Each DATA sample SHALL update a 16-bit CRC register.
- Polynomial: x^16+x^12+x^5+1, initial value 0, MSB first.
- Update: fb = crc[15]^dat_in; crc <= {crc[14:12], crc[11]^fb, crc[10:5], crc[4]^fb, crc[3:0], fb}.
REQ-021 Each DATA sample SHALL shift into a byte shift register.
REQ-022 On the sample completing a byte, rx_byte and rx_byte_vld=1 SHALL appear on the following cycle (latency 1); rx_byte_vld is high for exactly one cycle per byte.
REQ-023 In CRC, the block SHALL shift the 16 samples MSB-first into rx_crc[15:0]; the computed CRC is frozen during this state.
REQ-024 In END, dat_in=0 SHALL set rx_end_err.
REQ-025 rx_crc_err SHALL be set when rx_crc differs from the computed CRC.
REQ-026 rx_done SHALL pulse in the DONE cycle, with all status flags valid in that cycle; rx_busy drops in the same cycle.
REQ-027 The bit counter SHALL be 15 bits, counting blk_len*8 bits with wrap-free arithmetic; blk_len=1 yields exactly 8 DATA cycles.
REQ-028 On a timeout, rx_crc_err and rx_end_err SHALL remain 0 and no rx_byte_vld is issued.
REQ-029 sd_rst at any state, including mid-block, SHALL force IDLE on the next edge, clear all outputs and internal registers, and suppress rx_done for the aborted block.

Reset
REQ-030 With rstn=0, the block SHALL asynchronously enter IDLE with all of the following at 0: rx_byte, rx_byte_vld, rx_busy, rx_done, status flags, CRC register, and counters.
REQ-031 After rstn deasserts, the block SHALL ignore dat_in until rx_start.

Verification
REQ-032 blk_len=512, start bit, 512 bytes of 0xFF, CRC 0x7FA1, end bit 1 -> 512 rx_byte_vld strobes of 0xFF, rx_done with all flags 0.
REQ-033 Same stream with CRC 0x7FA0 -> rx_crc_err=1, rx_end_err=0, rx_done once.
REQ-034 blk_len=1, byte 0xA5, correct CRC, end bit 0 -> rx_byte=0xA5 one cycle after the 8th data sample, rx_end_err=1, rx_crc_err=0.
REQ-035 rx_timeout=10, dat_in held 1 -> rx_timeout_err=1 and rx_done after 10 WAIT_START cycles, no rx_byte_vld.
REQ-036 sd_rst pulsed during byte 3 of a 512-byte block -> IDLE next cycle, rx_busy=0, no rx_done; a following full block receives cleanly.
REQ-037 rx_start pulsed while in DATA -> ignored; the current block completes with the original blk_len.
